// File: rtl/uart_ui_pkg.sv
// Shared definitions for the UART board demo user-interface controllers
// (sender and receiver sides).
package uart_ui_pkg;

  typedef enum logic {
    LIVE   = 1'b0,
    BROWSE = 1'b1
  } ui_mode_t;

  localparam int         DEPTH_DEF      = 8;
  localparam int         LED_CYCLES_DEF = 5_000_000;
  localparam logic [3:0] ERR_MAX        = 4'd15;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a bank of debounced button levels.
// The previous-level register resets to 0, so a button held through reset
// reports an edge in the first cycle after reset.
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= '0;
    else     prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/receiver_controller.sv
// Receive-side UI controller: byte history ring, live/browse display,
// error counter, data-lost flag and stretched activity LED.
//
//   state  | meaning
//   LIVE   | newest byte shown, offset held at 0, step buttons ignored
//   BROWSE | offset steps through history, tracks arrivals to keep the byte
module receiver_controller
  import uart_ui_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LED_CYCLES = LED_CYCLES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_err,
  input  logic                     s0,
  input  logic                     s1,
  input  logic                     s2,
  input  logic                     s3,
  input  logic                     s4,
  output logic [7:0]               show_data,
  output logic [$clog2(DEPTH)-1:0] show_offset,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     browse,
  output logic                     lost,
  output logic [3:0]               err_cnt,
  output logic                     rx_led
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LED_CYCLES + 1);

  logic [4:0] btn_rise;
  logic       s0e, s1e, s2e, s3e, s4e;

  btn_edge #(.W(5)) u_btn_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i ({s4, s3, s2, s1, s0}),
    .rise_o  (btn_rise)
  );

  assign {s4e, s3e, s2e, s1e, s0e} = btn_rise;

  logic [7:0]    ring_q [DEPTH];
  ui_mode_t      mode_q, mode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [CW-1:0] count_q, count_d;
  logic          lost_q, lost_d;
  logic [3:0]    err_q, err_d;
  logic [LW-1:0] led_q, led_d;
  logic [7:0]    show_q, show_d;
  logic          rx_led_q, rx_led_d;
  logic          wr_en;
  logic          acc, err_hit;
  int            off_sum, off_lim;
  logic [AW-1:0] rd_idx;

  assign acc     = rx_valid & ~rx_err;
  assign err_hit = rx_valid & rx_err;

  always_comb begin
    mode_d   = mode_q;
    wr_ptr_d = wr_ptr_q;
    offset_d = offset_q;
    count_d  = count_q;
    lost_d   = lost_q;
    err_d    = err_q;
    led_d    = (led_q != '0) ? led_q - LW'(1) : led_q;
    wr_en    = 1'b0;
    off_sum  = 0;
    off_lim  = 0;

    if (s2e) begin
      // Clear drops any byte arriving in the same cycle.
      mode_d   = LIVE;
      wr_ptr_d = '0;
      offset_d = '0;
      count_d  = '0;
      lost_d   = 1'b0;
      err_d    = '0;
    end else begin
      if (acc) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
        led_d    = LW'(LED_CYCLES - 1);
        if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
      end
      if (err_hit && (err_q != ERR_MAX)) err_d = err_q + 4'd1;

      case (mode_q)
        LIVE: begin
          offset_d = '0;
          if (s3e && !s0e) mode_d = BROWSE;
        end
        BROWSE: begin
          if (s0e) begin
            mode_d   = LIVE;
            offset_d = '0;
            lost_d   = 1'b0;
          end else begin
            // Arrivals push the offset so the displayed byte stays put.
            off_sum = int'(offset_q) + int'(acc) + int'(s4e) - int'(s1e);
            off_lim = (count_d == '0) ? 0 : int'(count_d) - 1;
            if (off_sum < 0)            off_sum = 0;
            else if (off_sum > off_lim) off_sum = off_lim;
            offset_d = off_sum[AW-1:0];
            if (int'(offset_q) + int'(acc) > DEPTH - 1) lost_d = 1'b1;
          end
        end
        default: mode_d = LIVE;
      endcase
    end

    // Display the post-update view; bypass the slot being written this cycle.
    rd_idx = wr_ptr_d - AW'(1) - offset_d;
    if (count_d == '0)                      show_d = 8'h00;
    else if (wr_en && (rd_idx == wr_ptr_q)) show_d = rx_data;
    else                                    show_d = ring_q[rd_idx];

    rx_led_d = (acc && !s2e) || (led_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= LIVE;
      wr_ptr_q <= '0;
      offset_q <= '0;
      count_q  <= '0;
      lost_q   <= 1'b0;
      err_q    <= '0;
      led_q    <= '0;
      show_q   <= 8'h00;
      rx_led_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      wr_ptr_q <= wr_ptr_d;
      offset_q <= offset_d;
      count_q  <= count_d;
      lost_q   <= lost_d;
      err_q    <= err_d;
      led_q    <= led_d;
      show_q   <= show_d;
      rx_led_q <= rx_led_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) ring_q[wr_ptr_q] <= rx_data;
  end

  assign show_data   = show_q;
  assign show_offset = offset_q;
  assign count       = count_q;
  assign browse      = (mode_q == BROWSE);
  assign lost        = lost_q;
  assign err_cnt     = err_q;
  assign rx_led      = rx_led_q;

endmodule
